// File: rtl/tf_addr_sched.sv
`default_nettype none
// ============================================================================
// Module      : tf_addr_sched
// Description : Twiddle-ROM address sequencer for a two-lane NTT/INTT pass,
//               with valid/last/stage sideband aligned to 1-cycle ROM latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tf_addr_sched #(
    parameter int STAGE_CNT = 8,
    parameter int ADDR_W    = STAGE_CNT - 1,
    parameter int STG_W     = $clog2(STAGE_CNT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              inv,
    input  logic              ready,
    output logic              busy,
    output logic [ADDR_W-1:0] rom_addr0,
    output logic [ADDR_W-1:0] rom_addr1,
    output logic [STG_W-1:0]  rom_stage,
    output logic              tf_valid,
    output logic [STG_W-1:0]  tf_stage,
    output logic              tf_last,
    output logic              done
);

    localparam int              CYC_W     = STAGE_CNT - 2;
    localparam logic [CYC_W-1:0] c_CYC_MAX = '1;
    localparam logic [CYC_W-1:0] c_CYC_ONE = CYC_W'(1);
    localparam logic [STG_W-1:0] c_STG_TOP = STG_W'(STAGE_CNT - 1);
    localparam logic [STG_W-1:0] c_STG_ONE = STG_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CYC_W-1:0]  r_cyc;
    logic [CYC_W-1:0]  w_cyc_nxt;
    logic [STG_W-1:0]  r_stg;
    logic [STG_W-1:0]  w_stg_nxt;
    logic              r_inv;
    logic              w_inv_nxt;
    logic              r_tf_valid;
    logic              r_tf_last;
    logic [STG_W-1:0]  r_tf_stage;

    logic              w_issue;
    logic              w_cyc_max;
    logic              w_stg_last;
    logic [ADDR_W-1:0] w_num0;
    logic [ADDR_W-1:0] w_num1;
    logic [STG_W-1:0]  w_sh;

    assign w_issue    = (r_state == S_RUN) && ready;
    assign w_cyc_max  = (r_cyc == c_CYC_MAX);
    assign w_stg_last = r_inv ? (r_stg == '0) : (r_stg == c_STG_TOP);

    // Stage s owns 2^s twiddles, so the butterfly index is scaled down by S-1-s.
    assign w_num0 = ADDR_W'({r_cyc, 1'b0});
    assign w_num1 = ADDR_W'({r_cyc, 1'b1});
    assign w_sh   = c_STG_TOP - r_stg;

    always_comb begin
        w_state_nxt = r_state;
        w_cyc_nxt   = r_cyc;
        w_stg_nxt   = r_stg;
        w_inv_nxt   = r_inv;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_inv_nxt   = inv;
                    w_stg_nxt   = inv ? c_STG_TOP : '0;
                    w_cyc_nxt   = '0;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_issue) begin
                    if (w_cyc_max) begin
                        w_cyc_nxt = '0;
                        if (w_stg_last) begin
                            // Park the stage at 0 so idle addresses read as 0.
                            w_stg_nxt   = '0;
                            w_state_nxt = S_DRAIN;
                        end else if (r_inv) begin
                            w_stg_nxt = r_stg - c_STG_ONE;
                        end else begin
                            w_stg_nxt = r_stg + c_STG_ONE;
                        end
                    end else begin
                        w_cyc_nxt = r_cyc + c_CYC_ONE;
                    end
                end
            end
            S_DRAIN: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cyc      <= '0;
            r_stg      <= '0;
            r_inv      <= 1'b0;
            r_tf_valid <= 1'b0;
            r_tf_last  <= 1'b0;
            r_tf_stage <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cyc      <= w_cyc_nxt;
            r_stg      <= w_stg_nxt;
            r_inv      <= w_inv_nxt;
            r_tf_valid <= w_issue;
            r_tf_last  <= w_issue && w_cyc_max;
            r_tf_stage <= r_stg;
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DRAIN);
    assign rom_addr0 = w_num0 >> w_sh;
    assign rom_addr1 = w_num1 >> w_sh;
    assign rom_stage = r_stg;
    assign tf_valid  = r_tf_valid;
    assign tf_last   = r_tf_last;
    assign tf_stage  = r_tf_stage;

endmodule
`default_nettype wire

// File: tb/tb_tf_addr_sched.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_tf_addr_sched
// Description : Self-checking bench: issue-index reference model plus directed
//               passes (forward, inverse, back-pressure, abort, ignored start).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tf_addr_sched;

    localparam int S    = 8;
    localparam int AW   = S - 1;
    localparam int SW   = 3;
    localparam int PER  = 1 << (S - 2);
    localparam int NISS = S * PER;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          inv = 1'b0;
    logic          ready = 1'b0;
    logic          busy;
    logic [AW-1:0] rom_addr0;
    logic [AW-1:0] rom_addr1;
    logic [SW-1:0] rom_stage;
    logic          tf_valid;
    logic [SW-1:0] tf_stage;
    logic          tf_last;
    logic          done;

    tf_addr_sched #(.STAGE_CNT(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .inv       (inv),
        .ready     (ready),
        .busy      (busy),
        .rom_addr0 (rom_addr0),
        .rom_addr1 (rom_addr1),
        .rom_stage (rom_stage),
        .tf_valid  (tf_valid),
        .tf_stage  (tf_stage),
        .tf_last   (tf_last),
        .done      (done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cnt   = 0;
    int t0    = 0;
    int n_valid, n_last, n_done, first_last, last_last, done_rel;
    bit bp_en = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cnt - t0);
        end
    endtask

    always @(posedge clk) cnt <= cnt + 1;

    // Back-pressure pattern 1,0,0,1 relative to the start cycle.
    always @(posedge clk) begin
        #2;
        if (bp_en) ready = (((cnt - t0) % 4) == 0) || (((cnt - t0) % 4) == 3);
    end

    // Reference model: a pass is just issue number k = 0..NISS-1.
    function automatic int stage_of(input int k, input bit iv);
        return iv ? (S - 1 - k / PER) : (k / PER);
    endfunction

    function automatic int addr_of(input int k, input bit iv, input int lane);
        int s;
        s = stage_of(k, iv);
        return (2 * (k % PER) + lane) >> (S - 1 - s);
    endfunction

    bit m_active, m_inv, m_issue;
    int m_k;
    bit e_valid, e_last, e_done;
    int e_stage;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active <= 1'b0; m_inv <= 1'b0; m_k <= 0;
            e_valid <= 1'b0; e_last <= 1'b0; e_done <= 1'b0; e_stage <= 0;
        end else begin
            m_issue = m_active && ready;
            e_valid <= m_issue;
            e_last  <= m_issue && ((m_k % PER) == PER - 1);
            e_done  <= m_issue && (m_k == NISS - 1);
            e_stage <= stage_of(m_k, m_inv);
            if (!m_active && !e_done && start) begin
                m_active <= 1'b1;
                m_k      <= 0;
                m_inv    <= inv;
            end else if (m_issue) begin
                if (m_k == NISS - 1) m_active <= 1'b0;
                m_k <= m_k + 1;
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", int'(busy), int'(m_active || e_done));
        chk("tf_valid", int'(tf_valid), int'(e_valid));
        chk("tf_last", int'(tf_last), int'(e_last));
        chk("done", int'(done), int'(e_done));
        if (m_active) begin
            chk("rom_stage", int'(rom_stage), stage_of(m_k, m_inv));
            chk("rom_addr0", int'(rom_addr0), addr_of(m_k, m_inv, 0));
            chk("rom_addr1", int'(rom_addr1), addr_of(m_k, m_inv, 1));
        end
        if (e_valid) chk("tf_stage", int'(tf_stage), e_stage);
        if (tf_valid) n_valid++;
        if (tf_last) begin
            n_last++;
            if (n_last == 1) first_last = cnt - t0;
            last_last = cnt - t0;
        end
        if (done) begin
            n_done++;
            done_rel = cnt - t0;
        end
    end

    task automatic clr();
        n_valid = 0; n_last = 0; n_done = 0;
        first_last = -1; last_last = -1; done_rel = -1;
    endtask

    // All stimulus tasks start and end 1 time unit after a rising edge.
    task automatic to_rel(input int n);
        while (cnt - t0 < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic begin_pass(input logic iv);
        @(posedge clk);
        #1;
        start = 1'b1;
        inv   = iv;
        t0    = cnt;
        clr();
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int lim);
        int i;
        i = 0;
        while (n_done == 0 && i < lim) begin
            @(posedge clk);
            #1;
            i++;
        end
        if (n_done == 0) chk("done_timeout", 0, 1);
    endtask

    task automatic spot(input string nm, input int rel, input int s, input int a0, input int a1);
        to_rel(rel);
        chk({nm, "_stage"}, int'(rom_stage), s);
        chk({nm, "_a0"}, int'(rom_addr0), a0);
        chk({nm, "_a1"}, int'(rom_addr1), a1);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_busy"}, int'(busy), 0);
        chk({nm, "_valid"}, int'(tf_valid), 0);
        chk({nm, "_last"}, int'(tf_last), 0);
        chk({nm, "_done"}, int'(done), 0);
        chk({nm, "_a0"}, int'(rom_addr0), 0);
        chk({nm, "_a1"}, int'(rom_addr1), 0);
        chk({nm, "_stage"}, int'(rom_stage), 0);
        chk({nm, "_tfstage"}, int'(tf_stage), 0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        clr();
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        t0 = cnt;
        clr();
        to_rel(20);
        chk("idle_valid_cnt", n_valid, 0);
        chk("idle_busy", int'(busy), 0);

        ready = 1'b1;
        begin_pass(1'b0);
        spot("fwd_s0", 10, 0, 0, 0);
        spot("fwd_s3c5", 198, 3, 0, 0);
        spot("fwd_s6c5", 390, 6, 5, 5);
        spot("fwd_s7c5", 454, 7, 10, 11);
        wait_done(700);
        chk("fwd_done_cycle", done_rel, 513);
        chk("fwd_done_cnt", n_done, 1);
        chk("fwd_valid_cnt", n_valid, NISS);
        chk("fwd_last_cnt", n_last, 8);
        chk("fwd_first_last", first_last, 65);
        chk("fwd_last_last", last_last, 513);
        chk("fwd_busy_after", int'(busy), 0);

        begin_pass(1'b1);
        spot("inv_first", 1, 7, 0, 1);
        spot("inv_s6", 65, 6, 0, 0);
        spot("inv_last", 512, 0, 0, 0);
        wait_done(700);
        chk("inv_done_cycle", done_rel, 513);
        chk("inv_valid_cnt", n_valid, NISS);

        bp_en = 1'b1;
        begin_pass(1'b0);
        spot("bp_s7c5", 908, 7, 10, 11);
        spot("bp_hold", 910, 7, 12, 13);
        wait_done(1500);
        chk("bp_done_cycle", done_rel, 1025);
        chk("bp_valid_cnt", n_valid, NISS);
        chk("bp_last_cnt", n_last, 8);
        bp_en = 1'b0;
        ready = 1'b1;

        begin_pass(1'b0);
        to_rel(101);
        rst_n = 1'b0;
        #1;
        chk_zero("abort");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        t0 = cnt;
        to_rel(30);
        chk("abort_no_done", n_done, 0);
        chk("abort_busy", int'(busy), 0);

        begin_pass(1'b0);
        to_rel(50);
        start = 1'b1;
        inv   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        to_rel(513);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        inv   = 1'b0;
        to_rel(540);
        chk("ign_done_cnt", n_done, 1);
        chk("ign_done_cycle", done_rel, 513);
        chk("ign_valid_cnt", n_valid, NISS);
        chk("ign_busy", int'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
